// File: rtl/i2c_master_cmd.sv
// i2c_master_cmd: byte-level I2C master executing START / WRITE / READ / STOP commands
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   sda, scl        open-drain bus lines, driven 0 or z only
//   cmd_valid/ready command handshake; cmd 0=START 1=WRITE 2=READ 3=STOP
//   cmd_data        byte to send on WRITE; cmd_nack = NACK after a READ byte
//   rsp_valid       one-cycle completion pulse carrying rsp_data / rsp_nack / rsp_err
//   rsp_err         0=ok 1=arbitration lost 2=SCL timeout 3=illegal command
//   busy            bus is owned (state is not IDLE)
module i2c_master_cmd #(
    parameter int DIV   = 62,
    parameter int DIV_W = 8,
    parameter int TMO_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        sda,
    inout  wire        scl,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic [1:0] rsp_err,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, HOLD, START, RESTART, BIT, STOP} state_t;
    localparam logic [DIV_W-1:0] QMAX = DIV_W'(DIV);

    state_t           state, state_nx;
    logic [DIV_W-1:0] qcnt;
    logic [1:0]       q;
    logic [3:0]       bcnt;
    logic [TMO_W-1:0] tmo;
    logic [7:0]       dat;
    logic [8:0]       sh;
    logic             rd, nack_q, sda_last;
    logic             sda_low, scl_low;
    logic             accept, stall, tmo_hit, q_end, done, sample, bit_rel, arb_lost;

    assign sda = sda_low ? 1'b0 : 1'bz;
    assign scl = scl_low ? 1'b0 : 1'bz;

    assign accept  = cmd_valid && cmd_ready;
    // Released SCL still low at a quarter start means a slave is stretching.
    assign stall   = !scl_low && !scl && qcnt == '0 && state != IDLE && state != HOLD;
    assign tmo_hit = stall && tmo == '1;
    assign q_end   = !stall && qcnt == QMAX;
    assign done    = q_end && q == 2'd3;
    assign sample  = state == BIT && !stall && q == 2'd3 && qcnt == '0;
    // Bits 8..1 carry data, bit 0 is the acknowledge slot.
    assign bit_rel = rd ? (bcnt != 4'd0 || nack_q) : (bcnt == 4'd0 || dat[7]);
    assign arb_lost = ((state == START || state == RESTART) && !stall && q == 2'd1 && qcnt == '0 && !sda)
                   || (sample && !rd && bcnt != 4'd0 && dat[7] && !sda);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (tmo_hit || arb_lost) state_nx = IDLE;
        else begin
            case (state)
                IDLE:          if (accept && cmd == 2'd0 && sda && scl) state_nx = START;
                HOLD:          if (accept) state_nx = cmd == 2'd0 ? RESTART : cmd == 2'd3 ? STOP : BIT;
                START, RESTART: if (done) state_nx = HOLD;
                BIT:           if (done && bcnt == 4'd0) state_nx = HOLD;
                STOP:          if (done) state_nx = IDLE;
                default:       state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        sda_low   = 1'b0;
        scl_low   = 1'b0;
        cmd_ready = (state == IDLE || state == HOLD) && !rsp_valid;
        busy      = state != IDLE;
        case (state)
            HOLD:    begin sda_low = sda_last; scl_low = 1'b1; end
            START:   begin sda_low = q[1]; scl_low = q == 2'd3; end
            RESTART: begin sda_low = q[1]; scl_low = q == 2'd0 || q == 2'd3; end
            BIT:     begin sda_low = !bit_rel; scl_low = !q[1]; end
            STOP:    begin sda_low = !q[1]; scl_low = q == 2'd0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            qcnt      <= '0;
            q         <= '0;
            bcnt      <= '0;
            tmo       <= '0;
            dat       <= '0;
            sh        <= '0;
            rd        <= 1'b0;
            nack_q    <= 1'b0;
            sda_last  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_nack  <= 1'b0;
            rsp_err   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            sda_last  <= sda_low;
            tmo       <= stall ? tmo + 1'b1 : '0;
            if (state_nx != state || state == IDLE || state == HOLD) begin
                qcnt <= '0;
                q    <= '0;
            end else if (!stall) begin
                qcnt <= q_end ? '0 : qcnt + 1'b1;
                q    <= q + {1'b0, q_end};
            end
            if (accept) begin
                dat    <= cmd_data;
                rd     <= cmd == 2'd2;
                nack_q <= cmd_nack;
                bcnt   <= 4'd8;
                if (state == IDLE && (cmd != 2'd0 || !sda || !scl)) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= cmd != 2'd0 ? 2'd3 : 2'd1;
                end
            end
            if (sample) sh <= {sh[7:0], sda};
            if (state == BIT && done) begin
                dat <= {dat[6:0], 1'b0};
                if (bcnt != 4'd0) bcnt <= bcnt - 4'd1;
            end
            if (tmo_hit || arb_lost) begin
                rsp_valid <= 1'b1;
                rsp_err   <= tmo_hit ? 2'd2 : 2'd1;
            end else if (done && state != BIT) begin
                rsp_valid <= 1'b1;
                rsp_err   <= (state == STOP && !sda) ? 2'd1 : 2'd0;
            end else if (done && bcnt == 4'd0) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 2'd0;
                if (rd) rsp_data <= sh[8:1];
                else    rsp_nack <= sh[0];
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_cmd.sv
// tb_i2c_master_cmd: randomized bench for i2c_master_cmd with a bus-level slave and bus monitor
module tb_i2c_master_cmd;
    localparam int DIV = 1;
    localparam int Q   = DIV + 1;
    localparam int TW  = 6;

    logic clk = 1'b0, reset = 1'b0;
    wire  sda, scl;
    logic sda_s = 1'b0, scl_s = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_nack = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_nack, busy;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;

    int n_chk = 0, n_fail = 0;
    int mode = 0, nedge = 0, arb_k = -1, st_k = -1, st_len = 0, st_cnt = 0;
    int n_start = 0, n_stop = 0, n_low = 0;
    logic       slave_ack = 1'b0;
    logic [7:0] txs = 8'd0;
    logic [8:0] bits = 9'd0;

    pullup (sda);
    pullup (scl);
    assign sda = sda_s ? 1'b0 : 1'bz;
    assign scl = scl_s ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_cmd #(.DIV(DIV), .DIV_W(4), .TMO_W(TW)) dut (
        .clk(clk), .reset(reset), .sda(sda), .scl(scl),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_data(cmd_data),
        .cmd_nack(cmd_nack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_nack(rsp_nack), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor plus slave: records SDA at each SCL rise, detects START/STOP,
    // answers bytes, stretches SCL and emulates a competing master.
    initial begin
        logic s_p, d_p, s_n, d_n;
        s_p = 1'b1;
        d_p = 1'b1;
        forever begin
            @(negedge clk);
            s_n = scl;
            d_n = sda;
            if (s_n && s_p && d_p && !d_n) n_start++;
            if (s_n && s_p && !d_p && d_n) n_stop++;
            if (!s_n || !d_n) n_low++;
            if (scl_s && st_len > 0) begin
                st_cnt++;
                if (st_cnt >= st_len) begin
                    scl_s  = 1'b0;
                    st_len = 0;
                end
            end
            if (s_n && !s_p) begin
                bits = {bits[7:0], d_n};
                nedge++;
            end
            if (!s_n && s_p) begin
                if (nedge == st_k) begin
                    scl_s  = 1'b1;
                    st_cnt = 0;
                    st_k   = -1;
                end
                if (mode == 1 && nedge == 8) sda_s = slave_ack;
                if (mode == 1 && nedge >= 9) begin
                    sda_s = 1'b0;
                    mode  = 0;
                end
                if (mode == 2) begin
                    if (nedge >= 1 && nedge < 8) begin
                        sda_s = !txs[7];
                        txs   = {txs[6:0], 1'b0};
                    end else if (nedge >= 8) sda_s = 1'b0;
                    if (nedge >= 9) mode = 0;
                end
                if (nedge == arb_k) begin
                    sda_s = 1'b1;
                    arb_k = -1;
                end
            end
            s_p = s_n;
            d_p = d_n;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic slave_set(input int m, input logic [7:0] t, input logic a);
        mode      = m;
        slave_ack = a;
        nedge     = 0;
        bits      = '0;
        txs       = {t[6:0], 1'b0};
        sda_s     = (m == 2) ? !t[7] : 1'b0;
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic nk);
        int w;
        w = 0;
        while (!cmd_ready && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        if (!cmd_ready) check("ready_wait", cmd_ready, 1);
        cmd = c; cmd_data = d; cmd_nack = nk; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("ready_drop", cmd_ready, 0);
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic nk, output int lat);
        issue(c, d, nk);
        lat = 0;
        while (!rsp_valid && lat < 5000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic do_start();
        int lat, s0;
        slave_set(0, 8'd0, 1'b0);
        s0 = n_start;
        run_cmd(2'd0, 8'd0, 1'b0, lat);
        check("start_lat", lat, 4 * Q);
        check("start_err", rsp_err, 0);
        check("start_busy", busy, 1);
        @(posedge clk); #1;
        check("start_seen", n_start - s0, 1);
    endtask

    task automatic do_stop();
        int lat, s0;
        slave_set(0, 8'd0, 1'b0);
        s0 = n_stop;
        run_cmd(2'd3, 8'd0, 1'b0, lat);
        check("stop_lat", lat, 4 * Q);
        check("stop_err", rsp_err, 0);
        check("stop_busy", busy, 0);
        @(posedge clk); #1;
        check("stop_seen", n_stop - s0, 1);
        check("stop_bus", {30'd0, scl, sda}, 3);
    endtask

    task automatic do_write(input logic [7:0] d, input logic a, input int extra);
        int lat;
        slave_set(1, 8'd0, a);
        run_cmd(2'd1, d, 1'b0, lat);
        check("wr_lat", lat, 36 * Q + extra);
        check("wr_err", rsp_err, 0);
        check("wr_nack", rsp_nack, !a);
        check("wr_bits", bits, {d, !a});
    endtask

    task automatic do_read(input logic [7:0] t, input logic nk);
        int lat;
        slave_set(2, t, 1'b0);
        run_cmd(2'd2, 8'd0, nk, lat);
        check("rd_lat", lat, 36 * Q);
        check("rd_err", rsp_err, 0);
        check("rd_data", rsp_data, t);
        check("rd_bits", bits, {t, nk});
    endtask

    initial begin
        int lat, l0, w;
        logic [7:0] d;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_err", rsp_err, 0);
        check("rst_bus", {30'd0, scl, sda}, 3);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int c = 1; c < 4; c++) begin
            slave_set(0, 8'd0, 1'b0);
            l0 = n_low;
            run_cmd(2'(c), 8'($urandom), 1'($urandom), lat);
            check("ill_lat", lat, 0);
            check("ill_err", rsp_err, 3);
            check("ill_busy", busy, 0);
            repeat (3) @(posedge clk); #1;
            check("ill_pulse", rsp_valid, 0);
            check("ill_bus", n_low - l0, 0);
        end

        do_start();
        do_write(8'hA4, 1'b1, 0);
        do_stop();
        do_start();
        do_read(8'h5C, 1'b1);
        do_stop();

        repeat (3) begin
            do_start();
            repeat (5) begin
                case ($urandom_range(0, 2))
                    0: do_write(8'($urandom), 1'($urandom), 0);
                    1: do_read(8'($urandom), 1'($urandom));
                    default: do_start();
                endcase
            end
            do_stop();
        end

        do_start();
        slave_set(1, 8'd0, 1'b1);
        arb_k = 2;
        run_cmd(2'd1, 8'hFF, 1'b0, lat);
        check("arb_lat", lat, 8 * Q + 3 * Q + 1);
        check("arb_err", rsp_err, 1);
        check("arb_busy", busy, 0);
        check("arb_scl", scl, 1);
        mode = 0; sda_s = 1'b0; #1;
        check("arb_sda", sda, 1);

        sda_s = 1'b1;
        run_cmd(2'd0, 8'd0, 1'b0, lat);
        check("bb_lat", lat, 0);
        check("bb_err", rsp_err, 1);
        check("bb_busy", busy, 0);
        sda_s = 1'b0;

        do_start();
        st_k = 5; st_len = 44;
        do_write(8'($urandom), 1'b1, 44 - 2 * Q);
        do_stop();

        do_start();
        slave_set(1, 8'd0, 1'b1);
        st_k = 5; st_len = 400;
        run_cmd(2'd1, 8'($urandom), 1'b0, lat);
        check("tmo_err", rsp_err, 2);
        check("tmo_busy", busy, 0);
        check("tmo_min", lat >= 5 * 4 * Q + 2 * Q + (1 << TW) - 1, 1);
        scl_s = 1'b0; st_len = 0; mode = 0; sda_s = 1'b0; #1;
        check("tmo_bus", {30'd0, scl, sda}, 3);

        do_start();
        do_write(8'($urandom), 1'b0, 0);
        d = 8'($urandom);
        slave_set(2, d, 1'b0);
        issue(2'd2, 8'd0, 1'b0);
        w = 0;
        while (nedge < 4 && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        if (nedge < 4) check("rst_wait", nedge, 4);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; mode = 0; sda_s = 1'b0;
        @(posedge clk); #1;
        check("mid_bus", {30'd0, scl, sda}, 3);
        check("mid_ready", cmd_ready, 1);
        check("mid_busy", busy, 0);
        check("mid_valid", rsp_valid, 0);
        check("mid_data", rsp_data, 0);
        check("mid_nack", rsp_nack, 0);
        check("mid_err", rsp_err, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
